// File: rtl/up_down_sweep_ctrl.sv
// up_down_sweep_ctrl: triangle-sweep sequencer owning an N-bit up/down counter between latched bounds.
// Optional pause input compiled in when SWEEP_PAUSE_EN is defined.
`default_nettype none

module up_down_sweep_ctrl #(
   parameter int N       = 4,
   parameter int DWELL_W = 4,
   parameter int CYC_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
`ifdef SWEEP_PAUSE_EN
   input  logic               pause,
`endif
   input  logic [N-1:0]       lo,
   input  logic [N-1:0]       hi,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [CYC_W-1:0]   cycles,
   output logic [N-1:0]       q,
   output logic               ctrl,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [CYC_W-1:0]   cyc_cnt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_UP       = 3'd1,
      S_DWELL_HI = 3'd2,
      S_DOWN     = 3'd3,
      S_DWELL_LO = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       q_q, q_d;
   logic               ctrl_q, ctrl_d;
   logic               cfg_err_q, cfg_err_d;
   logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
   logic [DWELL_W-1:0] timer_q, timer_d;
   logic [N-1:0]       lo_q, lo_d;
   logic [N-1:0]       hi_q, hi_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [CYC_W-1:0]   cycles_q, cycles_d;

   logic               run;
   logic               hold;
   logic [CYC_W-1:0]   cyc_inc;

   assign run     = (state_q == S_UP) || (state_q == S_DWELL_HI) ||
                    (state_q == S_DOWN) || (state_q == S_DWELL_LO);
   assign cyc_inc = cyc_cnt_q + CYC_W'(1);

`ifdef SWEEP_PAUSE_EN
   assign hold = pause & run;
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      ctrl_d    = ctrl_q;
      cfg_err_d = 1'b0;
      cyc_cnt_d = cyc_cnt_q;
      timer_d   = timer_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      dwell_d   = dwell_q;
      cycles_d  = cycles_q;

      // Abort beats pause and every other transition; q and cyc_cnt are left as they are.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else if (!hold) begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  if (lo < hi) begin
                     lo_d      = lo;
                     hi_d      = hi;
                     dwell_d   = dwell;
                     cycles_d  = cycles;
                     q_d       = lo;
                     ctrl_d    = 1'b0;
                     cyc_cnt_d = '0;
                     state_d   = S_UP;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end
            end
            S_UP: begin
               if (q_q != hi_q) begin
                  q_d = q_q + N'(1);
               end else begin
                  ctrl_d = 1'b1;
                  if (dwell_q != '0) begin
                     timer_d = dwell_q;
                     state_d = S_DWELL_HI;
                  end else begin
                     state_d = S_DOWN;
                  end
               end
            end
            S_DWELL_HI: begin
               if (timer_q == DWELL_W'(1)) state_d = S_DOWN;
               else                        timer_d = timer_q - DWELL_W'(1);
            end
            S_DOWN: begin
               if (q_q != lo_q) begin
                  q_d = q_q - N'(1);
               end else begin
                  cyc_cnt_d = cyc_inc;
                  if ((cycles_q != '0) && (cyc_inc == cycles_q)) begin
                     state_d = S_DONE;
                  end else begin
                     ctrl_d = 1'b0;
                     if (dwell_q != '0) begin
                        timer_d = dwell_q;
                        state_d = S_DWELL_LO;
                     end else begin
                        state_d = S_UP;
                     end
                  end
               end
            end
            S_DWELL_LO: begin
               if (timer_q == DWELL_W'(1)) state_d = S_UP;
               else                        timer_d = timer_q - DWELL_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         q_q       <= '0;
         ctrl_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         cyc_cnt_q <= '0;
         timer_q   <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         dwell_q   <= '0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         ctrl_q    <= ctrl_d;
         cfg_err_q <= cfg_err_d;
         cyc_cnt_q <= cyc_cnt_d;
         timer_q   <= timer_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         dwell_q   <= dwell_d;
         cycles_q  <= cycles_d;
      end
   end

   assign q       = q_q;
   assign ctrl    = ctrl_q;
   assign busy    = run;
   assign done    = (state_q == S_DONE);
   assign cfg_err = cfg_err_q;
   assign cyc_cnt = cyc_cnt_q;

endmodule

`default_nettype wire
